// File: rtl/pixel_arbiter_pkg.sv
// Shared types and widths for the sprite pixel arbiter.
// Pure declarations: no logic, no latency, no flow control.
package pixel_arbiter_pkg;

    localparam int LAYER_W = 2;
    localparam int SRC_W   = 4;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_OUT
    } state_t;

endpackage

// File: rtl/pixel_arbiter_if.sv
// Sprite request / BRAM / video-output bundle; master = sprite+memory side, slave = arbiter.
// Wires only: no latency, no backpressure; blank/bg_color exist only with PIXEL_ARBITER_BG_EN.
interface pixel_arbiter_if
    import pixel_arbiter_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int ADDR_W      = 16,
    parameter int PIXEL_W     = 12
);
    logic [NUM_SPRITES-1:0]         req;
    logic [LAYER_W*NUM_SPRITES-1:0] layer_in;
    logic [ADDR_W*NUM_SPRITES-1:0]  addr_in;
    logic                           bram_en;
    logic [ADDR_W-1:0]              bram_addr;
    logic [PIXEL_W-1:0]             bram_dout;
    logic [PIXEL_W-1:0]             pixel_out;
    logic                           pixel_valid;
    logic [SRC_W-1:0]               pixel_src;
    logic                           overrun;
`ifdef PIXEL_ARBITER_BG_EN
    logic                           blank;
    logic [PIXEL_W-1:0]             bg_color;

    modport master (
        output req, layer_in, addr_in, bram_dout, blank, bg_color,
        input  bram_en, bram_addr, pixel_out, pixel_valid, pixel_src, overrun
    );
    modport slave (
        input  req, layer_in, addr_in, bram_dout, blank, bg_color,
        output bram_en, bram_addr, pixel_out, pixel_valid, pixel_src, overrun
    );
`else
    modport master (
        output req, layer_in, addr_in, bram_dout,
        input  bram_en, bram_addr, pixel_out, pixel_valid, pixel_src, overrun
    );
    modport slave (
        input  req, layer_in, addr_in, bram_dout,
        output bram_en, bram_addr, pixel_out, pixel_valid, pixel_src, overrun
    );
`endif

endinterface

// File: rtl/pixel_arbiter_layer_select.sv
// Combinational selector: requesting sprite with the highest layer wins, lowest index on ties.
// Zero latency; no flow control.
module layer_select
    import pixel_arbiter_pkg::*;
#(
    parameter int NUM_SPRITES = 4
) (
    input  logic [NUM_SPRITES-1:0]         i_req,
    input  logic [LAYER_W*NUM_SPRITES-1:0] i_layer,
    output logic [IDX_W-1:0]               o_winner,
    output logic                           o_any_req
);

    logic               w_found;
    logic [LAYER_W-1:0] w_best;

    // Strict '>' keeps the earlier (lower) index when layers are equal.
    always_comb begin
        o_winner  = '0;
        o_any_req = |i_req;
        w_found   = 1'b0;
        w_best    = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (i_req[i] && (!w_found || (i_layer[LAYER_W*i +: LAYER_W] > w_best))) begin
                w_found  = 1'b1;
                w_best   = i_layer[LAYER_W*i +: LAYER_W];
                o_winner = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pixel_arbiter.sv
// Per-slot layer-priority arbiter onto one sprite BRAM port; background fill under PIXEL_ARBITER_BG_EN.
// req->pixel_valid 3 clk; no backpressure: requests while busy are dropped and flagged on sticky overrun.
module pixel_arbiter
    import pixel_arbiter_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int ADDR_W      = 16,
    parameter int PIXEL_W     = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk25en,
    pixel_arbiter_if.slave bus
);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_take;
    logic                          w_any_req;
    logic [IDX_W-1:0]              w_winner;
    logic [IDX_W-1:0]              r_winner;
    logic [ADDR_W*NUM_SPRITES-1:0] r_addr;
    logic [ADDR_W-1:0]             w_rd_addr;
    logic [PIXEL_W-1:0]            r_pixel;
    logic [SRC_W-1:0]              r_src;
    logic                          r_overrun;

    layer_select #(
        .NUM_SPRITES (NUM_SPRITES)
    ) u_layer_select (
        .i_req     (bus.req),
        .i_layer   (bus.layer_in),
        .o_winner  (w_winner),
        .o_any_req (w_any_req)
    );

`ifdef PIXEL_ARBITER_BG_EN
    logic r_slot_start;
    logic r_blank_d;
    logic r_bg;
    logic w_bg_take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_start <= 1'b0;
            r_blank_d    <= 1'b0;
        end else begin
            r_slot_start <= clk25en;
            r_blank_d    <= bus.blank;
        end
    end

    // A real sprite request always beats the background fill.
    assign w_bg_take = (r_state == ST_IDLE) && !w_any_req && r_slot_start && !r_blank_d;
`else
    logic w_unused_clk25en;
    assign w_unused_clk25en = clk25en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_READ;
                end
`ifdef PIXEL_ARBITER_BG_EN
                else if (w_bg_take) begin
                    w_state_nxt = ST_WAIT;
                end
`endif
            end
            ST_READ: w_state_nxt = ST_WAIT;
            ST_WAIT: w_state_nxt = ST_OUT;
            ST_OUT:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_addr = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (r_winner == IDX_W'(i)) w_rd_addr = r_addr[ADDR_W*i +: ADDR_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winner  <= '0;
            r_addr    <= '0;
            r_pixel   <= '0;
            r_src     <= '0;
            r_overrun <= 1'b0;
`ifdef PIXEL_ARBITER_BG_EN
            r_bg      <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_winner <= w_winner;
                r_addr   <= bus.addr_in;
            end
`ifdef PIXEL_ARBITER_BG_EN
            if (w_take || w_bg_take) r_bg <= w_bg_take;
            if (r_state == ST_WAIT) begin
                r_pixel <= r_bg ? bus.bg_color : bus.bram_dout;
                r_src   <= r_bg ? '0 : {1'b1, r_winner};
            end
`else
            if (r_state == ST_WAIT) begin
                r_pixel <= bus.bram_dout;
                r_src   <= {1'b1, r_winner};
            end
`endif
            if (w_any_req && (r_state != ST_IDLE)) r_overrun <= 1'b1;
        end
    end

    assign bus.bram_en     = (r_state == ST_READ);
    assign bus.bram_addr   = (r_state == ST_READ) ? w_rd_addr : '0;
    assign bus.pixel_out   = r_pixel;
    assign bus.pixel_valid = (r_state == ST_OUT);
    assign bus.pixel_src   = r_src;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Bench for pixel_arbiter: slot-level model plus hand-computed pins; BG test under PIXEL_ARBITER_BG_EN.
module tb_pixel_arbiter;

    localparam int NS    = 4;
    localparam int AW    = 16;
    localparam int PW    = 12;
    localparam int DEPTH = 2048;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic clk25en = 1'b0;

    pixel_arbiter_if #(.NUM_SPRITES(NS), .ADDR_W(AW), .PIXEL_W(PW)) bus ();

    pixel_arbiter #(.NUM_SPRITES(NS), .ADDR_W(AW), .PIXEL_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk25en (clk25en),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int valid_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Sprite RAM contents: 0x0040 -> 0x0F0, 0x1234 -> 0x6CC, 0x0100 -> 0x330.
    function automatic logic [PW-1:0] mem_of(input logic [AW-1:0] a);
        logic [PW-1:0] t;
        t = a[PW-1:0];
        return PW'(t * 3 + 12'h030);
    endfunction

    logic [PW-1:0] bram_q = '0;
    always @(posedge clk) if (bus.bram_en) bram_q <= mem_of(bus.bram_addr);
    assign bus.bram_dout = bram_q;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    function automatic int model_winner(input logic [NS-1:0] rq, input logic [2*NS-1:0] ly);
        int best;
        best = -1;
        for (int i = 0; i < NS; i++)
            if (rq[i] && int'(ly[2*i +: 2]) > best) best = int'(ly[2*i +: 2]);
        for (int i = 0; i < NS; i++)
            if (rq[i] && int'(ly[2*i +: 2]) == best) return i;
        return 0;
    endfunction

    // Model: a slot timeline of expected events keyed by cycle.
    logic          exp_en    [DEPTH];
    logic [AW-1:0] exp_addr  [DEPTH];
    logic          exp_valid [DEPTH];
    logic [PW-1:0] exp_pix   [DEPTH];
    logic [3:0]    exp_src   [DEPTH];

    initial begin
        int            k;
        int            w;
        int            busy_until;
        logic          m_overrun;
        logic [PW-1:0] hold_pix;
        logic [3:0]    hold_src;
        logic          prev_en;
        logic          prev_blank;
        logic [AW-1:0] a;
        busy_until = 0;
        m_overrun  = 1'b0;
        hold_pix   = '0;
        hold_src   = '0;
        prev_en    = 1'b0;
        prev_blank = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_en[i] = 1'b0; exp_addr[i] = '0; exp_valid[i] = 1'b0; exp_pix[i] = '0; exp_src[i] = '0;
        end
        forever begin
            @(negedge clk);
            k = cyc;
            if (k + 4 >= DEPTH) begin
                $display("FAIL model_depth at cycle %0d: got %0d expected below %0d", k, k, DEPTH - 4);
                $fatal(1);
            end
            if (rst) begin
                check("rst_bram_en", 32'(bus.bram_en), 32'd0);
                check("rst_pixel_valid", 32'(bus.pixel_valid), 32'd0);
                check("rst_pixel_out", 32'(bus.pixel_out), 32'd0);
                check("rst_pixel_src", 32'(bus.pixel_src), 32'd0);
                check("rst_overrun", 32'(bus.overrun), 32'd0);
                for (int j = k; j <= k + 4; j++) begin
                    exp_en[j] = 1'b0; exp_valid[j] = 1'b0;
                end
                busy_until = 0;
                m_overrun  = 1'b0;
                hold_pix   = '0;
                hold_src   = '0;
                prev_en    = 1'b0;
            end else begin
                if (exp_valid[k]) begin
                    hold_pix = exp_pix[k];
                    hold_src = exp_src[k];
                end
                check("bram_en", 32'(bus.bram_en), 32'(exp_en[k]));
                if (exp_en[k]) check("bram_addr", 32'(bus.bram_addr), 32'(exp_addr[k]));
                check("pixel_valid", 32'(bus.pixel_valid), 32'(exp_valid[k]));
                check("pixel_out", 32'(bus.pixel_out), 32'(hold_pix));
                check("pixel_src", 32'(bus.pixel_src), 32'(hold_src));
                check("overrun", 32'(bus.overrun), 32'(m_overrun));
                if (bus.pixel_valid) valid_seen++;
                if (k >= busy_until) begin
                    if (|bus.req) begin
                        w = model_winner(bus.req, bus.layer_in);
                        a = bus.addr_in[AW*w +: AW];
                        exp_en[k+1]    = 1'b1;
                        exp_addr[k+1]  = a;
                        exp_valid[k+3] = 1'b1;
                        exp_pix[k+3]   = mem_of(a);
                        exp_src[k+3]   = 4'(8 + w);
                        busy_until     = k + 4;
                    end
`ifdef PIXEL_ARBITER_BG_EN
                    else if (prev_en && !prev_blank) begin
                        exp_valid[k+2] = 1'b1;
                        exp_pix[k+2]   = bus.bg_color;
                        exp_src[k+2]   = 4'h0;
                        busy_until     = k + 3;
                    end
`endif
                end else if (|bus.req) begin
                    m_overrun = 1'b1;
                end
                prev_en = clk25en;
`ifdef PIXEL_ARBITER_BG_EN
                prev_blank = bus.blank;
`endif
            end
        end
    end

    task automatic drive(input logic [NS-1:0] rq, input logic [2*NS-1:0] ly, input logic [AW*NS-1:0] ad);
        @(posedge clk); #1;
        bus.req = rq; bus.layer_in = ly; bus.addr_in = ad; clk25en = 1'b1;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.req = '0; clk25en = 1'b0;
    endtask

    task automatic pin_slot(input string name, input logic [NS-1:0] rq, input logic [2*NS-1:0] ly,
                            input logic [AW*NS-1:0] ad, input logic [AW-1:0] ea,
                            input logic [PW-1:0] epix, input logic [3:0] esrc);
        drive(rq, ly, ad);
        idle_cycle();
        @(negedge clk);
        check({name, "_t1_en"}, 32'(bus.bram_en), 32'd1);
        check({name, "_t1_addr"}, 32'(bus.bram_addr), 32'(ea));
        idle_cycle();
        idle_cycle();
        @(negedge clk);
        check({name, "_t3_valid"}, 32'(bus.pixel_valid), 32'd1);
        check({name, "_t3_pixel"}, 32'(bus.pixel_out), 32'(epix));
        check({name, "_t3_src"}, 32'(bus.pixel_src), 32'(esrc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [AW*NS-1:0] ad;
        int v0;
        bus.req = '0; bus.layer_in = '0; bus.addr_in = '0;
`ifdef PIXEL_ARBITER_BG_EN
        bus.blank = 1'b1; bus.bg_color = 12'h00F;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) idle_cycle();

        pin_slot("single", 4'b0001, 8'h01, {16'h0, 16'h0, 16'h0, 16'h0040}, 16'h0040, 12'h0F0, 4'h8);
        pin_slot("layer", 4'b0101, 8'hF1, {16'hBEEF, 16'h1234, 16'h0000, 16'h0040}, 16'h1234, 12'h6CC, 4'hA);
        pin_slot("tie", 4'b1010, 8'hBB, {16'h0300, 16'h0BAD, 16'h0100, 16'h0DAD}, 16'h0100, 12'h330, 4'h9);

        v0 = valid_seen;
        for (int i = 0; i < 100; i++) begin
            for (int s = 0; s < NS; s++) ad[AW*s +: AW] = AW'(i * 64 + s * 7 + 5);
            drive(NS'((i % 15) + 1), 8'(i * 37 + 11), ad);
            repeat (3) idle_cycle();
        end
        repeat (4) idle_cycle();
        check("b2b_pulses", 32'(valid_seen - v0), 32'd100);
        check("b2b_overrun", 32'(bus.overrun), 32'd0);

        drive(4'b0001, 8'h01, {16'h0, 16'h0, 16'h0, 16'h0200});
        @(posedge clk); #1;
        bus.req = 4'b0100; clk25en = 1'b0;
        repeat (4) idle_cycle();
        check("overrun_set", 32'(bus.overrun), 32'd1);
        repeat (6) idle_cycle();
        check("overrun_sticky", 32'(bus.overrun), 32'd1);

        v0 = valid_seen;
        drive(4'b0010, 8'h0C, {16'h0, 16'h0, 16'h0AAA, 16'h0});
        @(posedge clk); #1;
        bus.req = '0; clk25en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_bram_en", 32'(bus.bram_en), 32'd0);
        check("midrst_overrun", 32'(bus.overrun), 32'd0);
        check("midrst_pixel_out", 32'(bus.pixel_out), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) idle_cycle();
        check("midrst_no_valid", 32'(valid_seen - v0), 32'd0);

`ifdef PIXEL_ARBITER_BG_EN
        bus.bg_color = 12'h00F;
        @(posedge clk); #1;
        clk25en = 1'b1; bus.blank = 1'b0; bus.req = '0;
        @(posedge clk); #1;
        clk25en = 1'b0; bus.blank = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bg_valid", 32'(bus.pixel_valid), 32'd1);
        check("bg_pixel", 32'(bus.pixel_out), 32'h00F);
        check("bg_src", 32'(bus.pixel_src), 32'd0);
        check("bg_no_bram", 32'(bus.bram_en), 32'd0);
        repeat (4) idle_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_arbiter.md
Name: pixel_arbiter

Overview:
Sits directly downstream of the sprite (blob) blocks. Each pixel slot, it collects the single-cycle requests from all sprites and picks the winner by layer priority. It then performs one read on the shared sprite BRAM port and delivers the winning pixel colour to the video output stage with a valid strobe. One slot is four clk cycles, paced by clk25en.

Parameters:
NUM_SPRITES, 4, number of sprite request channels (2..8)
ADDR_W, 16, sprite RAM address width, equal to the sprite block's ram_add_width
PIXEL_W, 12, pixel colour width (RGB444)

Ports:
clk  input  1  system clock 100 MHz
rst  input  1  asynchronous, active-high reset
clk25en  input  1  25 MHz pixel clock enable
req  input  NUM_SPRITES  request pulses, bit i from sprite i
layer_in  input  2*NUM_SPRITES  layer of sprite i at bits [2i+1:2i]; higher value is nearer the viewer
addr_in  input  ADDR_W*NUM_SPRITES  pixel address of sprite i at bits [ADDR_W*i +: ADDR_W]
bram_en  output  1  BRAM read enable, one-cycle pulse
bram_addr  output  ADDR_W  BRAM read address
bram_dout  input  PIXEL_W  BRAM read data, valid 1 cycle after bram_en
pixel_out  output  PIXEL_W  resolved pixel colour
pixel_valid  output  1  one-cycle strobe qualifying pixel_out
pixel_src  output  4  bit 3 set = sprite pixel; bits [2:0] = winning sprite index
overrun  output  1  sticky; set when a request is dropped

Behaviour:
- Reset (async, rst=1): all outputs 0, state IDLE, internal latches 0. Reset mid-read aborts the read; no pixel_valid is produced for it.
- States: IDLE, READ, WAIT, OUT.
- IDLE, any req bit = 1 (cycle T0):
  - Latch req, layer_in and addr_in.
  - Winner = requesting sprite with the maximum layer; ties go to the lowest index.
  - Go to READ.
- READ (T1): bram_en=1; bram_addr = winner address. Go to WAIT.
- WAIT (T2): bram_dout is valid. Register it into pixel_out, set pixel_src = {1, winner}, go to OUT.
- OUT (T3): pixel_valid=1 for this cycle only. Go to IDLE.
- Latency req -> pixel_valid: exactly 3 cycles. The FSM is back in IDLE in time for the next slot's request 4 cycles later.
- pixel_out and pixel_src hold their value until the next OUT.
- Any req bit seen outside IDLE: request ignored, overrun set to 1. overrun clears only on rst.
- req seen in IDLE with non-requesting channels: their layer/address values are ignored.
- Widths: winner index is 3 bits, zero-extended; layer compare is unsigned 2-bit.
- No combinational path from req to any output.

Optional Feature:
Macro PIXEL_ARBITER_BG_EN.
- With it:
  - Extra inputs blank (1 bit) and bg_color (PIXEL_W bits).
  - slot_start = clk25en delayed 1 cycle.
  - At slot_start, if blank delayed 1 cycle is 0, no req bit is set and the FSM is in IDLE, the FSM skips the BRAM. It goes IDLE -> WAIT -> OUT with pixel_out = bg_color and pixel_src = 0. Latency is still 3 cycles; bram_en stays 0.
- Without it: these ports do not exist, and slots with no request produce no pixel_valid.

Decomposition:
- Package pixel_arbiter_pkg:
  - FSM state enum (IDLE/READ/WAIT/OUT).
  - LAYER_W=2.
  - SRC_W=4.
  - Localparam for the winner index width.
- Sub-module layer_select: combinational max-layer, lowest-index-on-tie priority selector. Inputs: req mask and layer vector. Outputs: winner index and any_req. Instantiated once.

Test Plan:
- Single request: req=0001, layer0=1, addr0=0x0040, bram_dout=0x0F0 at T2 -> bram_en at T1 with addr 0x0040; pixel_valid at T3 with pixel_out=0x0F0, pixel_src=0x8.
- Layer priority: req=0101, layer0=1, layer2=3, addr2=0x1234 -> bram_addr=0x1234; pixel_src=0xA.
- Tie: req=1010, layer1=2, layer3=2 -> winner 1; pixel_src=0x9.
- Overrun: second req pulse at T1 -> ignored; no extra bram_en; overrun=1 and stays 1 until rst.
- Back-to-back slots: requests every 4 cycles for 100 slots -> 100 pixel_valid pulses, each 3 cycles after its req; overrun stays 0.
- Reset mid-operation: rst asserted during READ -> all outputs 0 immediately; no pixel_valid afterwards. Plus, with PIXEL_ARBITER_BG_EN: blank=0, no req at slot_start, bg_color=0x00F -> pixel_valid 3 cycles later with pixel_out=0x00F, pixel_src=0, bram_en never asserted.
